// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : core_pkg                                                   |
// | Shared helpers for the tournament branch predictor: the reset value  |
// | of a weakly-not-taken saturating counter and PC index extraction.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_pkg;

  // Weakly-not-taken / weakly-local value: 2^(ctr_w-1)-1
  function automatic int unsigned ctr_reset_weak_nt(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
  endfunction

  // Word-aligned table index: pc[idx_w+1:2], returned zero-extended
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_ctr_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sat_ctr_table                                              |
// | 2^IDX_W x CTR_W saturating counter array. One combinational read     |
// | port (MSB only), one inc/dec write port whose pre-update MSB is also |
// | exposed, synchronous reset of every entry to RESET_VAL.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_ctr_table #(
  parameter int IDX_W = 8,
  parameter int CTR_W = 2,
  parameter logic [CTR_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_msb,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_en,
  input  logic             wr_inc,
  output logic             wr_msb
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [CTR_W-1:0] r_ctr [ENTRIES];
  logic [CTR_W-1:0] w_old;
  logic [CTR_W-1:0] w_next;

  assign rd_msb = r_ctr[rd_idx][CTR_W-1];
  assign w_old  = r_ctr[wr_idx];
  assign wr_msb = w_old[CTR_W-1];

  // Saturating step toward taken (inc) or not-taken (dec)
  always_comb begin
    w_next = w_old;
    if (wr_inc) begin
      if (w_old != CTR_MAX) w_next = w_old + CTR_W'(1);
    end else begin
      if (w_old != '0) w_next = w_old - CTR_W'(1);
    end
  end

  // Table storage: reset all entries, otherwise write back the stepped counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= RESET_VAL;
    end else if (wr_en) begin
      r_ctr[wr_idx] <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predict_tournament.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_predict_tournament                                  |
// | Tournament predictor: bimodal local PHT, gshare global PHT and a     |
// | chooser. Predicts in D, trains in M with the carried gshare index.   |
// | Holds the committed-only GHR and saturating performance counters.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_predict_tournament
  import core_pkg::*;
#(
  parameter int IDX_W  = 8,
  parameter int GHR_W  = 8,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branchD,
  input  logic [31:0]       pcD,
  output logic              pred_takeD,
  output logic [IDX_W-1:0]  pred_idxD,
  input  logic              commitM,
  input  logic [31:0]       pcM,
  input  logic [IDX_W-1:0]  pred_idxM,
  input  logic              pred_takeM,
  input  logic              actual_takeM,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam logic [CTR_W-1:0]  CTR_RESET_WEAK_NT = CTR_W'(ctr_reset_weak_nt(CTR_W));
  localparam logic [STAT_W-1:0] STAT_MAX          = '1;

  logic [GHR_W-1:0]  r_ghr;
  logic [GHR_W-1:0]  w_ghr_next;
  logic [STAT_W-1:0] r_branch_cnt;
  logic [STAT_W-1:0] r_mispred_cnt;

  logic [IDX_W-1:0]  w_lidx_d;
  logic [IDX_W-1:0]  w_gidx_d;
  logic [IDX_W-1:0]  w_lidx_m;
  logic              w_loc_d_msb;
  logic              w_glob_d_msb;
  logic              w_cho_d_msb;
  logic              w_loc_m_msb;
  logic              w_glob_m_msb;
  logic              w_cho_m_msb_unused;
  logic              w_lp_ok;
  logic              w_gp_ok;

  assign w_lidx_d = IDX_W'(pc_index(pcD, IDX_W));
  assign w_lidx_m = IDX_W'(pc_index(pcM, IDX_W));
  assign w_gidx_d = w_lidx_d ^ IDX_W'(r_ghr);

  assign pred_idxD  = w_gidx_d;
  assign pred_takeD = branchD & (w_cho_d_msb ? w_glob_d_msb : w_loc_d_msb);

  // Chooser only moves when exactly one component was right (pre-update view)
  assign w_lp_ok = (w_loc_m_msb  == actual_takeM);
  assign w_gp_ok = (w_glob_m_msb == actual_takeM);

  sat_ctr_table #(.IDX_W(IDX_W), .CTR_W(CTR_W), .RESET_VAL(CTR_RESET_WEAK_NT)) u_local (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (w_lidx_d),
    .rd_msb (w_loc_d_msb),
    .wr_idx (w_lidx_m),
    .wr_en  (commitM),
    .wr_inc (actual_takeM),
    .wr_msb (w_loc_m_msb)
  );

  sat_ctr_table #(.IDX_W(IDX_W), .CTR_W(CTR_W), .RESET_VAL(CTR_RESET_WEAK_NT)) u_global (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (w_gidx_d),
    .rd_msb (w_glob_d_msb),
    .wr_idx (pred_idxM),
    .wr_en  (commitM),
    .wr_inc (actual_takeM),
    .wr_msb (w_glob_m_msb)
  );

  sat_ctr_table #(.IDX_W(IDX_W), .CTR_W(CTR_W), .RESET_VAL(CTR_RESET_WEAK_NT)) u_chooser (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (w_lidx_d),
    .rd_msb (w_cho_d_msb),
    .wr_idx (w_lidx_m),
    .wr_en  (commitM & (w_lp_ok ^ w_gp_ok)),
    .wr_inc (w_gp_ok),
    .wr_msb (w_cho_m_msb_unused)
  );

  generate
    if (GHR_W == 1) begin : g_ghr_single
      assign w_ghr_next = actual_takeM;
    end else begin : g_ghr_shift
      assign w_ghr_next = {r_ghr[GHR_W-2:0], actual_takeM};
    end
  endgenerate

  // Committed-only global history
  always_ff @(posedge clk) begin
    if (rst)          r_ghr <= '0;
    else if (commitM) r_ghr <= w_ghr_next;
  end

  // Saturating branch / mispredict counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (commitM) begin
      if (r_branch_cnt != STAT_MAX) r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if ((pred_takeM != actual_takeM) && (r_mispred_cnt != STAT_MAX))
        r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire
